// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle for lsu_mem_ctrl: execute-stage request/response handshakes plus the
// big-endian 64-bit data memory port. The LSU uses the slave view.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_add;
  logic [63:0] mem_in;
  logic [63:0] mem_out;
  logic        mem_rd;
  logic        mem_wr;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           resp_ready, mem_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_add, mem_in, mem_rd, mem_wr
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           resp_ready, mem_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_add, mem_in, mem_rd, mem_wr
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a big-endian 64-bit memory port with bounds checking and
// read-modify-write sub-dword stores. Optional: LSU_ALIGN_CHECK_EN rejects misaligned accesses.
module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);
  localparam logic [63:0] PARK_ADDR = 64'hFFFF_FFFF_FFFF_FFFF;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [63:0] mem_add_q, mem_add_d;
  logic [63:0] mem_in_q, mem_in_d;

  // The end address is formed in 65 bits so that a wrapping access is always out of range.
  function automatic logic access_err(input logic [63:0] addr, input logic [1:0] size);
    logic [64:0] end_addr;
    logic        misaligned;
    end_addr = {1'b0, addr} + (65'd1 << size);
`ifdef LSU_ALIGN_CHECK_EN
    misaligned = ((addr[2:0] & ((3'd1 << size) - 3'd1)) != 3'd0);
`else
    misaligned = 1'b0;
`endif
    access_err = (end_addr > MEM_LIMIT) | misaligned;
  endfunction

  function automatic logic [63:0] extend_load(input logic [63:0] d, input logic [1:0] size,
                                              input logic uns);
    case (size)
      2'd0:    extend_load = uns ? {56'd0, d[63:56]} : {{56{d[63]}}, d[63:56]};
      2'd1:    extend_load = uns ? {48'd0, d[63:48]} : {{48{d[63]}}, d[63:48]};
      2'd2:    extend_load = uns ? {32'd0, d[63:32]} : {{32{d[63]}}, d[63:32]};
      default: extend_load = d;
    endcase
  endfunction

  function automatic logic [63:0] merge_store(input logic [63:0] cap, input logic [63:0] w,
                                              input logic [1:0] size);
    case (size)
      2'd0:    merge_store = {w[7:0],  cap[55:0]};
      2'd1:    merge_store = {w[15:0], cap[47:0]};
      2'd2:    merge_store = {w[31:0], cap[31:0]};
      default: merge_store = w;
    endcase
  endfunction

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_add    = mem_add_q;
  assign bus.mem_in     = mem_in_q;

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_add_d    = PARK_ADDR;
    mem_in_d     = 64'd0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata;
          if (access_err(bus.req_addr, bus.req_size)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 64'd0;
          end else if (bus.req_we && (bus.req_size == 2'd3)) begin
            state_d   = ST_WRITE;
            mem_wr_d  = 1'b1;
            mem_add_d = bus.req_addr;
            mem_in_d  = bus.req_wdata;
          end else begin
            state_d   = ST_READ;
            mem_rd_d  = 1'b1;
            mem_add_d = bus.req_addr;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (we_q) begin
          // Keep the address: the merged dword goes back to the location just read.
          state_d   = ST_WRITE;
          mem_wr_d  = 1'b1;
          mem_add_d = mem_add_q;
          mem_in_d  = merge_store(bus.mem_out, wdata_q, size_q);
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = extend_load(bus.mem_out, size_q, uns_q);
        end
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 64'd0;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 64'd0;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 64'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      wdata_q      <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 64'd0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_add_q    <= PARK_ADDR;
      mem_in_q     <= 64'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_add_q    <= mem_add_d;
      mem_in_q     <= mem_in_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: byte-array memory model, expected-response scoreboard
// and immediate-assertion checks. Honours LSU_ALIGN_CHECK_EN for the misaligned case.
module tb_lsu_mem_ctrl;
  logic clk;
  logic rst_n;
  logic mem_clear;
  int   checks;
  int   errors;
  int   rd_cnt;
  int   wr_cnt;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;
  exp_t sb[$];

  logic [7:0]  mem [0:255];
  logic [63:0] rd_word;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.MEM_BYTES(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational big-endian read; bytes past the array read as zero.
  always_comb begin
    rd_word = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (({1'b0, bus.mem_add} + 65'(i)) < 65'd256)
        rd_word[63-8*i -: 8] = mem[8'(bus.mem_add + 64'(i))];
      else
        rd_word[63-8*i -: 8] = 8'h00;
    end
  end
  assign bus.mem_out = rd_word;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.mem_wr) begin
      for (int i = 0; i < 8; i++)
        if (({1'b0, bus.mem_add} + 65'(i)) < 65'd256)
          mem[8'(bus.mem_add + 64'(i))] <= bus.mem_in[63-8*i -: 8];
    end
  end

  always @(posedge clk) begin
    if (bus.mem_rd === 1'b1) rd_cnt <= rd_cnt + 1;
    if (bus.mem_wr === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check64({tag, "_req_ready"},  64'(bus.req_ready),  64'd1);
    check64({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check64({tag, "_resp_err"},   64'(bus.resp_err),   64'd0);
    check64({tag, "_resp_rdata"}, bus.resp_rdata,      64'd0);
    check64({tag, "_mem_rd"},     64'(bus.mem_rd),     64'd0);
    check64({tag, "_mem_wr"},     64'(bus.mem_wr),     64'd0);
    check64({tag, "_mem_in"},     bus.mem_in,          64'd0);
    check64({tag, "_mem_add"},    bus.mem_add,         64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  // One transaction: latency and memory pulses follow from the request class.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_data, input logic exp_err,
                        input int hold, input string tag);
    exp_t e;
    exp_t got;
    int   n;
    int   rd0;
    int   wr0;
    logic [63:0] first_data;
    e.data = exp_err ? 64'd0 : exp_data;
    e.err  = exp_err;
    if (exp_err)                 begin e.lat = 0; e.nrd = 0; e.nwr = 0; end
    else if (!we)                begin e.lat = 1; e.nrd = 1; e.nwr = 0; end
    else if (size == 2'd3)       begin e.lat = 1; e.nrd = 0; e.nwr = 1; end
    else                         begin e.lat = 2; e.nrd = 1; e.nwr = 1; end
    sb.push_back(e);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = $urandom();
    bus.req_wdata    = {$urandom(), $urandom()};
    bus.req_unsigned = ~uns;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    got = sb.pop_front();
    check64({tag, "_lat"},   64'(n),              64'(got.lat));
    check64({tag, "_data"},  bus.resp_rdata,      got.data);
    check64({tag, "_err"},   64'(bus.resp_err),   64'(got.err));
    check64({tag, "_nrd"},   64'(rd_cnt - rd0),   64'(got.nrd));
    check64({tag, "_nwr"},   64'(wr_cnt - wr0),   64'(got.nwr));
    first_data = bus.resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check64({tag, "_hold_valid"}, 64'(bus.resp_valid), 64'd1);
      check64({tag, "_hold_data"},  bus.resp_rdata,      first_data);
      check64({tag, "_hold_rdy"},   64'(bus.req_ready),  64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check64({tag, "_done_valid"}, 64'(bus.resp_valid), 64'd0);
    check64({tag, "_done_rdy"},   64'(bus.req_ready),  64'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd_cnt = 0;
    wr_cnt = 0;
    rst_n = 1'b0;
    mem_clear = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 64'd0;
    bus.req_wdata = 64'd0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    mem_clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b1, 2'd3, 1'b0, 64'd8, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 0, "st_dw8");
    check64("mem8",  64'(mem[8]),  64'h01);
    check64("mem15", 64'(mem[15]), 64'hEF);
    check64("park_add", bus.mem_add, 64'hFFFF_FFFF_FFFF_FFFF);
    check64("park_in",  bus.mem_in,  64'd0);
    do_req(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 0, "ld_dw8");

    do_req(1'b1, 2'd0, 1'b0, 64'd16, 64'h80, 64'd0, 1'b0, 0, "st_b16");
    do_req(1'b1, 2'd0, 1'b0, 64'd17, 64'h01, 64'd0, 1'b0, 0, "st_b17");
    do_req(1'b0, 2'd0, 1'b0, 64'd16, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 0, "ld_bs16");
    do_req(1'b0, 2'd0, 1'b1, 64'd16, 64'd0, 64'h0000_0000_0000_0080, 1'b0, 0, "ld_bu16");
    do_req(1'b0, 2'd1, 1'b0, 64'd16, 64'd0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 0, "ld_hs16");

    do_req(1'b1, 2'd3, 1'b0, 64'd24, 64'h1111_1111_1111_1111, 64'd0, 1'b0, 0, "st_dw24");
    do_req(1'b1, 2'd1, 1'b0, 64'd24, 64'hBEEF, 64'd0, 1'b0, 0, "st_h24");
    do_req(1'b0, 2'd3, 1'b0, 64'd24, 64'd0, 64'hBEEF_1111_1111_1111, 1'b0, 0, "ld_dw24");

    do_req(1'b0, 2'd3, 1'b0, 64'd249, 64'd0, 64'd0, 1'b1, 0, "ld_dw249");
    do_req(1'b0, 2'd3, 1'b0, 64'd248, 64'd0, 64'd0, 1'b0, 0, "ld_dw248");
    do_req(1'b1, 2'd0, 1'b0, 64'd255, 64'h5A, 64'd0, 1'b0, 0, "st_b255");
    do_req(1'b0, 2'd0, 1'b1, 64'd255, 64'd0, 64'h5A, 1'b0, 0, "ld_b255");
    do_req(1'b0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1, 0, "ld_wrap");

    do_req(1'b1, 2'd1, 1'b0, 64'd18, 64'hC0DE, 64'd0, 1'b0, 0, "st_h18");
    do_req(1'b1, 2'd1, 1'b0, 64'd20, 64'h1234, 64'd0, 1'b0, 0, "st_h20");
`ifdef LSU_ALIGN_CHECK_EN
    do_req(1'b0, 2'd2, 1'b0, 64'd18, 64'd0, 64'd0, 1'b1, 0, "ld_w18");
`else
    do_req(1'b0, 2'd2, 1'b0, 64'd18, 64'd0, 64'hFFFF_FFFF_C0DE_1234, 1'b0, 0, "ld_w18");
`endif

    do_req(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 5, "bp_ld8");

    // Store to 32 cut by reset while its write is pending.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd3;
    bus.req_addr  = 64'd32;
    bus.req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check64("rst_in_write", 64'(bus.mem_wr), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    check64("rst_mem32", {mem[32], mem[33], mem[34], mem[35], mem[36], mem[37], mem[38], mem[39]},
            64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check64("rst_no_resp", 64'(bus.resp_valid), 64'd0);
    check64("rst_idle",    64'(bus.req_ready),  64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
